bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/bus_cycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller for a 6809-style CPU bus sampled from a fast PLL clock.
//
// The asynchronous E, Q and R/W inputs are synchronized into i_clk. A Q rise
// seen in IDLE latches the address and R/W, then decodes the cycle against
// BASE_ADDR/ADDR_MASK. Decoded cycles drive the data buffer enable/direction
// and emit one read or write strobe. A cycle counter in ACTIVE bounds how long
// a stuck E can hold the bus. Every output is registered.
//
// Ports:
//   i_clk        fast PLL clock, sole clock
//   i_reset      synchronous active-low reset
//   i_e_clk      6809 E clock (asynchronous)
//   i_q_clk      6809 Q clock (asynchronous)
//   i_rw         6809 R/W, 1 = read (asynchronous)
//   i_addr       6809 address bus (asynchronous, stable around Q rise)
//   i_e_hold     buffer hold window from the upstream E-delay stage
//   o_cs         decoded cycle in progress
//   o_buf_oe_n   data buffer enable, active low
//   o_buf_dir    1 = FPGA drives the CPU data bus, 0 = CPU drives
//   o_rd_strobe  one-cycle pulse, read data needed
//   o_wr_strobe  one-cycle pulse, write data valid
//   o_addr_lat   address latched for the current cycle
//   o_bus_err    one-cycle pulse on ACTIVE timeout
module bus_cycle_ctrl #(
    parameter logic [15:0] BASE_ADDR   = 16'hC000,
    parameter logic [15:0] ADDR_MASK   = 16'hF000,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_e_clk,
    input  logic        i_q_clk,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic        i_e_hold,
    output logic        o_cs,
    output logic        o_buf_oe_n,
    output logic        o_buf_dir,
    output logic        o_rd_strobe,
    output logic        o_wr_strobe,
    output logic [15:0] o_addr_lat,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {StIdle, StActive, StSkip, StHold} state_e;

    // [0] and [1] form the synchronizer, [2] is the edge-detect delay stage.
    logic [2:0]  e_sync_q, q_sync_q;
    logic [1:0]  rw_sync_q;
    // Counts real samples since reset so that a Q already high at release is not
    // mistaken for a fresh rise while the zeroed pipeline refills.
    logic [1:0]  warm_q;

    state_e      state_q, state_d;
    logic        cs_q, cs_d;
    logic        oe_n_q, oe_n_d;
    logic        dir_q, dir_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        rd_done_q, rd_done_d;
    logic [7:0]  cnt_q, cnt_d;

    logic e_s2, e_rise, e_fall, q_rise, rw_sync, addr_hit;

    assign e_s2     = e_sync_q[1];
    assign e_rise   = e_sync_q[1] & ~e_sync_q[2];
    assign e_fall   = ~e_sync_q[1] & e_sync_q[2];
    assign q_rise   = (warm_q == 2'd3) & q_sync_q[1] & ~q_sync_q[2];
    assign rw_sync  = rw_sync_q[1];
    assign addr_hit = (i_addr & ADDR_MASK) == BASE_ADDR;

    always_comb begin
        state_d   = state_q;
        cs_d      = 1'b0;
        oe_n_d    = 1'b1;
        dir_d     = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        rw_d      = rw_q;
        rd_done_d = rd_done_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (q_rise) begin
                    addr_d = i_addr;
                    rw_d   = rw_sync;
                    if (addr_hit) begin
                        state_d   = StActive;
                        cnt_d     = 8'd0;
                        rd_done_d = 1'b0;
                        cs_d      = 1'b1;
                        dir_d     = rw_sync;
                        oe_n_d    = ~e_s2;
                    end else begin
                        state_d = StSkip;
                    end
                end
            end
            StActive: begin
                cs_d   = 1'b1;
                dir_d  = rw_q;
                oe_n_d = ~e_s2;
                cnt_d  = cnt_q + 8'd1;
                if (rw_q && e_rise && !rd_done_q) begin
                    rd_d      = 1'b1;
                    rd_done_d = 1'b1;
                end
                // E fall has priority over a coincident timeout.
                if (e_fall) begin
                    wr_d    = ~rw_q;
                    state_d = StHold;
                    oe_n_d  = 1'b0;
                end else if (cnt_q == TIMEOUT_CYC - 8'd1) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                    cs_d    = 1'b0;
                    oe_n_d  = 1'b1;
                    dir_d   = 1'b0;
                end
            end
            StHold: begin
                cs_d   = 1'b1;
                oe_n_d = 1'b0;
                dir_d  = rw_q;
                // Leaving HOLD keeps cs asserted for one trailing cycle.
                if (!i_e_hold) begin
                    state_d = StIdle;
                    oe_n_d  = 1'b1;
                    dir_d   = 1'b0;
                end
            end
            StSkip: begin
                if (e_fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            e_sync_q  <= '0;
            q_sync_q  <= '0;
            rw_sync_q <= '0;
            warm_q    <= '0;
            state_q   <= StIdle;
            cs_q      <= 1'b0;
            oe_n_q    <= 1'b1;
            dir_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            rd_done_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            e_sync_q  <= {e_sync_q[1:0], i_e_clk};
            q_sync_q  <= {q_sync_q[1:0], i_q_clk};
            rw_sync_q <= {rw_sync_q[0], i_rw};
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
            state_q   <= state_d;
            cs_q      <= cs_d;
            oe_n_q    <= oe_n_d;
            dir_q     <= dir_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            rd_done_q <= rd_done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_cs        = cs_q;
    assign o_buf_oe_n  = oe_n_q;
    assign o_buf_dir   = dir_q;
    assign o_rd_strobe = rd_q;
    assign o_wr_strobe = wr_q;
    assign o_addr_lat  = addr_q;
    assign o_bus_err   = err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed bus cycles plus randomized
// ones, each scored against a transaction-level expectation derived from the
// decode window, the three-edge input latency and the ACTIVE cycle limit.
module tb_bus_cycle_ctrl;

    localparam logic [15:0] BASE = 16'hC000;
    localparam logic [15:0] MASK = 16'hF000;
    localparam int          TO   = 200;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_e_clk, i_q_clk, i_rw, i_e_hold;
    logic [15:0] i_addr;
    logic        o_cs, o_buf_oe_n, o_buf_dir, o_rd_strobe, o_wr_strobe, o_bus_err;
    logic [15:0] o_addr_lat;

    bus_cycle_ctrl #(
        .BASE_ADDR   (BASE),
        .ADDR_MASK   (MASK),
        .TIMEOUT_CYC (8'(TO))
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_e_clk     (i_e_clk),
        .i_q_clk     (i_q_clk),
        .i_rw        (i_rw),
        .i_addr      (i_addr),
        .i_e_hold    (i_e_hold),
        .o_cs        (o_cs),
        .o_buf_oe_n  (o_buf_oe_n),
        .o_buf_dir   (o_buf_dir),
        .o_rd_strobe (o_rd_strobe),
        .o_wr_strobe (o_wr_strobe),
        .o_addr_lat  (o_addr_lat),
        .o_bus_err   (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    // Posedge index; at a negedge it names the edge just taken.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: invariants every cycle, plus running event counters.
    bit   mon_en = 1'b0;
    int   n_rd = 0, n_wr = 0, n_err = 0, n_cs = 0, n_oe = 0;
    int   err_cyc = 0;
    logic err_oe_n = 1'b0;

    always @(negedge i_clk) begin
        if (mon_en) begin
            check_eq("strobe_excl", {31'b0, o_rd_strobe & o_wr_strobe}, 32'd0);
            check_eq("oe_implies_cs", {31'b0, ~o_buf_oe_n & ~o_cs}, 32'd0);
            if (o_rd_strobe) n_rd++;
            if (o_wr_strobe) n_wr++;
            if (o_cs) n_cs++;
            if (!o_buf_oe_n) n_oe++;
            if (o_bus_err) begin
                n_err++;
                err_cyc  = cyc;
                err_oe_n = o_buf_oe_n;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // One CPU bus cycle. lead: cycles from Q rise to E rise; e_len: cycles E is
    // high; hold_len: cycles i_e_hold stays up after E falls; extra_q: a second
    // Q pulse with a different address while E is high.
    task automatic bus_cycle(input logic [15:0] addr, input logic rw, input int lead,
                             input int e_len, input int hold_len, input bit extra_q);
        bit hit, tmo, live;
        int tq, rest, s_rd, s_wr, s_err, s_cs;
        hit  = ((addr & MASK) == BASE);
        // Q rise acts 2 edges after its sampling edge; ACTIVE may last TO cycles;
        // an E fall acting on the last ACTIVE edge still wins.
        tmo  = hit && (lead + e_len >= TO + 1);
        live = hit && !tmo;
        s_rd = n_rd; s_wr = n_wr; s_err = n_err; s_cs = n_cs;

        i_addr = addr;
        i_rw   = rw;
        tick(2);
        i_q_clk = 1'b1;
        tq = cyc + 1;
        tick(lead);
        i_e_clk  = 1'b1;
        i_e_hold = 1'b1;
        tick(5);
        check_eq("mid_cs", o_cs, hit);
        check_eq("mid_oe_n", o_buf_oe_n, !hit);
        check_eq("mid_dir", o_buf_dir, hit & rw);
        i_q_clk = 1'b0;
        rest = e_len - 5;
        if (extra_q) begin
            tick(2);
            i_addr  = addr ^ 16'h0F0F;
            i_q_clk = 1'b1;
            tick(3);
            i_q_clk = 1'b0;
            tick(1);
            rest -= 6;
        end
        tick(rest);
        i_e_clk = 1'b0;
        if (hold_len >= 5) begin
            tick(4);
            check_eq("hold_cs", o_cs, live);
            check_eq("hold_oe_n", o_buf_oe_n, !live);
            check_eq("hold_dir", o_buf_dir, live & rw);
            tick(hold_len - 4);
        end else begin
            tick(hold_len);
        end
        i_e_hold = 1'b0;
        tick(6);

        check_eq("end_cs", o_cs, 0);
        check_eq("end_oe_n", o_buf_oe_n, 1);
        check_eq("end_dir", o_buf_dir, 0);
        check_eq("addr_lat", o_addr_lat, addr);
        check_eq("rd_count", n_rd - s_rd, hit & rw);
        check_eq("wr_count", n_wr - s_wr, live & !rw);
        check_eq("err_count", n_err - s_err, tmo);
        check_eq("cs_seen", (n_cs - s_cs) != 0, hit);
        if (tmo) begin
            check_eq("err_cycle", err_cyc, tq + 2 + TO);
            check_eq("err_oe_n", err_oe_n, 1);
        end
    endtask

    initial begin
        logic [15:0] a;
        int          lead, e_len, hold, s_cs, s_wr, s_oe;
        bit          rw, extra;

        i_reset  = 1'b0;
        i_e_clk  = 1'b0;
        i_q_clk  = 1'b0;
        i_rw     = 1'b0;
        i_e_hold = 1'b0;
        i_addr   = 16'h0000;
        tick(3);
        check_eq("rst_cs", o_cs, 0);
        check_eq("rst_oe_n", o_buf_oe_n, 1);
        check_eq("rst_dir", o_buf_dir, 0);
        check_eq("rst_rd", o_rd_strobe, 0);
        check_eq("rst_wr", o_wr_strobe, 0);
        check_eq("rst_err", o_bus_err, 0);
        check_eq("rst_addr", o_addr_lat, 16'h0000);
        mon_en  = 1'b1;
        i_reset = 1'b1;
        tick(4);

        bus_cycle(16'hC123, 1'b1, 2, 50, 8, 1'b0);   // decoded read
        bus_cycle(16'hCFFF, 1'b0, 2, 30, 6, 1'b0);   // decoded write
        bus_cycle(16'hB000, 1'b1, 2, 30, 6, 1'b0);   // outside window
        bus_cycle(16'hC040, 1'b1, 2, 300, 6, 1'b0);  // stuck E -> timeout
        bus_cycle(16'hC041, 1'b0, 2, 198, 6, 1'b0);  // E fall coincides with limit
        bus_cycle(16'hC042, 1'b0, 2, 199, 6, 1'b0);  // one cycle past the limit
        bus_cycle(16'hC010, 1'b1, 2, 30, 6, 1'b1);   // extra Q pulse, read
        bus_cycle(16'hC011, 1'b0, 2, 30, 6, 1'b1);   // extra Q pulse, write

        // Reset while holding the buffers open.
        i_addr = 16'hC456;
        i_rw   = 1'b1;
        tick(2);
        i_q_clk = 1'b1;
        tick(2);
        i_e_clk  = 1'b1;
        i_e_hold = 1'b1;
        tick(8);
        i_q_clk = 1'b0;
        tick(4);
        i_e_clk = 1'b0;
        tick(4);
        check_eq("pre_rst_oe_n", o_buf_oe_n, 0);
        check_eq("pre_rst_cs", o_cs, 1);
        i_reset = 1'b0;
        tick(1);
        check_eq("hold_rst_cs", o_cs, 0);
        check_eq("hold_rst_oe_n", o_buf_oe_n, 1);
        check_eq("hold_rst_dir", o_buf_dir, 0);
        check_eq("hold_rst_addr", o_addr_lat, 16'h0000);
        i_reset = 1'b1;
        tick(3);
        check_eq("post_rst_cs", o_cs, 0);
        i_e_hold = 1'b0;
        tick(4);

        // Reset released with a decoded cycle already under way.
        i_reset = 1'b0;
        i_addr  = 16'hC200;
        i_rw    = 1'b0;
        i_q_clk = 1'b1;
        tick(2);
        i_reset = 1'b1;
        s_cs = n_cs; s_wr = n_wr; s_oe = n_oe;
        tick(3);
        i_e_clk  = 1'b1;
        i_e_hold = 1'b1;
        tick(8);
        i_q_clk = 1'b0;
        tick(4);
        i_e_clk = 1'b0;
        tick(3);
        i_e_hold = 1'b0;
        tick(6);
        check_eq("inflight_cs", n_cs - s_cs, 0);
        check_eq("inflight_wr", n_wr - s_wr, 0);
        check_eq("inflight_oe", n_oe - s_oe, 0);
        check_eq("inflight_addr", o_addr_lat, 16'h0000);
        bus_cycle(16'hC300, 1'b1, 1, 20, 5, 1'b0);   // first fresh Q rise decodes

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) a = {4'hC, 12'($urandom)};
            else                           a = 16'($urandom);
            rw   = 1'($urandom_range(0, 1));
            lead = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) e_len = $urandom_range(190, 210);
            else                           e_len = $urandom_range(12, 60);
            hold  = $urandom_range(0, 10);
            extra = (e_len < 100) && ($urandom_range(0, 3) == 0);
            bus_cycle(a, rw, lead, e_len, hold, extra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
